// File: rtl/btn_event_ctrl.sv
// Push-button debouncer with press and auto-repeat events, a W1C capture
// register and a maskable level interrupt, exposed as an Avalon-MM slave.
module btn_event_ctrl #(
  parameter int N_BTN       = 4,
  parameter int CNT_W       = 26,
  parameter int DEB_CYCLES  = 500000,
  parameter int LONG_CYCLES = 50000000,
  parameter int REP_CYCLES  = 10000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  input  logic [N_BTN-1:0] btn_n_in
);

  typedef enum logic [2:0] {IDLE, DEB_P, HELD, RPT, DEB_R} btn_state_t;

  localparam logic [1:0] ADDR_STATE   = 2'd0;
  localparam logic [1:0] ADDR_CTRL    = 2'd1;
  localparam logic [1:0] ADDR_MASK    = 2'd2;
  localparam logic [1:0] ADDR_CAPTURE = 2'd3;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [N_BTN-1:0] sync_q1;
  logic [N_BTN-1:0] sync_q2;
  logic [1:0]       ctrl;
  logic [N_BTN-1:0] mask;
  logic [N_BTN-1:0] capture;
  logic [N_BTN-1:0] evt;
  logic [N_BTN-1:0] level;
  logic [N_BTN-1:0] clr;
  logic [31:0]      rd_mux;
  logic             wr_en;
  logic             en;
  logic             rep_en;
  logic             unused_wdata;

  assign en           = ctrl[0];
  assign rep_en       = ctrl[1];
  assign wr_en        = chipselect && !write_n;
  assign clr          = (wr_en && address == ADDR_CAPTURE) ? writedata[N_BTN-1:0] : '0;
  assign unused_wdata = ^writedata;

  // Two-flop synchroniser on the inverted (active-high) button levels.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= ~btn_n_in;
      sync_q2 <= sync_q1;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             p;
    logic             evt_b;

    assign p        = sync_q2[i];
    assign evt[i]   = evt_b;
    assign level[i] = (state == HELD) || (state == RPT) || (state == DEB_R);

    always_comb begin
      // NOTE: default assignment first so no path leaves evt_b unassigned (no latch).
      evt_b = 1'b0;
      if (en && p) begin
        case (state)
          DEB_P:   evt_b = (cnt == DEB_LAST);
          HELD:    evt_b = rep_en && (cnt == LONG_LAST);
          RPT:     evt_b = rep_en && (cnt == REP_LAST);
          default: evt_b = 1'b0;
        endcase
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state <= IDLE;
        cnt   <= '0;
      end else if (!en) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (p) begin
              state <= DEB_P;
              cnt   <= '0;
            end
          end
          DEB_P: begin
            if (!p) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (evt_b) begin
              state <= HELD;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          HELD: begin
            if (!p) begin
              state <= DEB_R;
              cnt   <= '0;
            end else if (evt_b) begin
              state <= RPT;
              cnt   <= '0;
            end else if (cnt != CNT_MAX) begin
              cnt <= cnt + CNT_ONE;
            end
          end
          RPT: begin
            // With REP_EN cleared the timer just saturates and no further events fire.
            if (!p) begin
              state <= DEB_R;
              cnt   <= '0;
            end else if (evt_b) begin
              cnt <= '0;
            end else if (cnt != CNT_MAX) begin
              cnt <= cnt + CNT_ONE;
            end
          end
          DEB_R: begin
            if (p) begin
              state <= HELD;
              cnt   <= '0;
            end else if (cnt == DEB_LAST) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl    <= '0;
      mask    <= '0;
      capture <= '0;
    end else begin
      if (wr_en && address == ADDR_CTRL) ctrl <= writedata[1:0];
      if (wr_en && address == ADDR_MASK) mask <= writedata[N_BTN-1:0];
      // A new event beats a same-cycle W1C clear of that bit.
      capture <= (capture & ~clr) | evt;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_STATE:   rd_mux = 32'(level);
      ADDR_CTRL:    rd_mux = 32'(ctrl);
      ADDR_MASK:    rd_mux = 32'(mask);
      ADDR_CAPTURE: rd_mux = 32'(capture);
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end

  assign irq = |(capture & mask);

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Bench for btn_event_ctrl: directed scenarios plus a randomized run checked
// every cycle against a run-length based behavioural model.
module tb_btn_event_ctrl;
  localparam int N_BTN = 4;
  localparam int CNT_W = 26;
  localparam int DEB   = 4;
  localparam int LONG  = 20;
  localparam int REP   = 8;

  logic             clk        = 1'b0;
  logic             reset_n    = 1'b0;
  logic [1:0]       address    = '0;
  logic             chipselect = 1'b0;
  logic             write_n    = 1'b1;
  logic [31:0]      writedata  = '0;
  logic [31:0]      readdata;
  logic             irq;
  logic [N_BTN-1:0] btn_n_in   = '1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  btn_event_ctrl #(
    .N_BTN(N_BTN), .CNT_W(CNT_W), .DEB_CYCLES(DEB),
    .LONG_CYCLES(LONG), .REP_CYCLES(REP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq),
    .btn_n_in(btn_n_in)
  );

  // Reference model: a press is accepted after DEB+1 consecutive pressed samples,
  // a release after DEB+1 consecutive released samples; repeats fire LONG and then
  // every REP samples after the hold (re)started.
  bit [N_BTN-1:0] m_s1, m_s2, m_lvl, m_cap, m_mask;
  bit [1:0]       m_ctrl;
  int             m_run   [N_BTN];
  int             m_t     [N_BTN];
  bit             m_alive [N_BTN];
  logic [31:0]    m_rd;
  logic           m_irq;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_cap = '0; m_mask = '0; m_ctrl = '0;
      m_rd = '0; m_irq = 1'b0;
      for (int i = 0; i < N_BTN; i++) begin
        m_run[i] = 0; m_t[i] = 0; m_alive[i] = 1'b0;
      end
    end else begin : model_step
      bit [N_BTN-1:0] ev;
      bit [N_BTN-1:0] clr;
      bit             p;
      bit             wr;
      ev = '0;
      case (address)
        2'd0:    m_rd = 32'(m_lvl);
        2'd1:    m_rd = 32'(m_ctrl);
        2'd2:    m_rd = 32'(m_mask);
        default: m_rd = 32'(m_cap);
      endcase
      for (int i = 0; i < N_BTN; i++) begin
        p = m_s2[i];
        if (!m_ctrl[0]) begin
          m_lvl[i] = 1'b0; m_run[i] = 0; m_t[i] = 0; m_alive[i] = 1'b0;
        end else if (!m_lvl[i]) begin
          if (p) begin
            m_run[i]++;
            if (m_run[i] == DEB + 1) begin
              ev[i] = 1'b1; m_lvl[i] = 1'b1; m_run[i] = 0; m_t[i] = 0; m_alive[i] = 1'b1;
            end
          end else begin
            m_run[i] = 0;
          end
        end else if (!p) begin
          m_run[i]++;
          if (m_run[i] == DEB + 1) begin
            m_lvl[i] = 1'b0; m_run[i] = 0;
          end
        end else if (m_run[i] != 0) begin
          m_run[i] = 0; m_t[i] = 0; m_alive[i] = 1'b1;
        end else begin
          m_t[i]++;
          if (m_alive[i] && m_t[i] >= LONG && (m_t[i] - LONG) % REP == 0) begin
            if (m_ctrl[1]) ev[i] = 1'b1;
            else           m_alive[i] = 1'b0;
          end
        end
      end
      wr  = chipselect && !write_n;
      clr = (wr && address == 2'd3) ? writedata[N_BTN-1:0] : '0;
      if (wr && address == 2'd1) m_ctrl = writedata[1:0];
      if (wr && address == 2'd2) m_mask = writedata[N_BTN-1:0];
      m_cap = (m_cap & ~clr) | ev;
      m_irq = |(m_cap & m_mask);
      m_s2  = m_s1;
      m_s1  = ~btn_n_in;
    end
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1;
    @(negedge clk);
    d = readdata; chipselect = 1'b0;
  endtask

  task automatic test_reset();
    bus_write(2'd1, 32'h1);
    bus_write(2'd2, 32'hF);
    btn_n_in = 4'b0111;
    repeat (10) @(negedge clk);
    address = 2'd3;
    @(negedge clk);
    n_cmp++;
    if (irq !== 1'b1) begin n_bad++; $display("FAIL pre_reset_irq: got %0b expected 1", irq); end
    n_cmp++;
    if (readdata !== 32'h8) begin n_bad++; $display("FAIL pre_reset_capture: got %0h expected 8", readdata); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (readdata !== 32'h0) begin n_bad++; $display("FAIL reset_readdata: got %0h expected 0", readdata); end
    n_cmp++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %0b expected 0", irq); end
    btn_n_in = '1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bus_read(2'd1, writedata);
    n_cmp++;
    if (writedata !== 32'h0) begin n_bad++; $display("FAIL reset_ctrl: got %0h expected 0", writedata); end
  endtask

  task automatic test_clean_press();
    logic [31:0] d;
    bus_write(2'd1, 32'h1);
    bus_write(2'd2, 32'hF);
    btn_n_in[0] = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      @(negedge clk);
      n_cmp++;
      if (irq !== (e == 7)) begin
        n_bad++; $display("FAIL press_irq_edge%0d: got %0b expected %0b", e, irq, e == 7);
      end
    end
    bus_read(2'd0, d);
    n_cmp++;
    if (d !== 32'h1) begin n_bad++; $display("FAIL press_state: got %0h expected 1", d); end
    bus_read(2'd3, d);
    n_cmp++;
    if (d !== 32'h1) begin n_bad++; $display("FAIL press_capture: got %0h expected 1", d); end
    bus_write(2'd3, 32'h1);
    n_cmp++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL w1c_irq: got %0b expected 0", irq); end
    bus_read(2'd3, d);
    n_cmp++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL w1c_capture: got %0h expected 0", d); end
    btn_n_in[0] = 1'b1;
    repeat (12) @(negedge clk);
    bus_read(2'd0, d);
    n_cmp++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL release_state: got %0h expected 0", d); end
  endtask

  task automatic test_bounce();
    logic [31:0] d;
    for (int c = 0; c < 20; c++) begin
      btn_n_in[1] = ((c / 2) % 2) != 0;
      @(negedge clk);
      n_cmp++;
      if (irq !== 1'b0) begin n_bad++; $display("FAIL bounce_irq_c%0d: got %0b expected 0", c, irq); end
    end
    btn_n_in[1] = 1'b1;
    repeat (8) @(negedge clk);
    bus_read(2'd3, d);
    n_cmp++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL bounce_capture: got %0h expected 0", d); end
    bus_read(2'd0, d);
    n_cmp++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL bounce_state: got %0h expected 0", d); end
  endtask

  task automatic test_auto_repeat();
    logic clr_pending;
    logic exp_irq;
    logic exp_state;
    clr_pending = 1'b0;
    bus_write(2'd1, 32'h3);
    btn_n_in[2] = 1'b0;
    for (int e = 1; e <= 72; e++) begin
      if (e == 61) btn_n_in[2] = 1'b1;
      if (clr_pending) begin
        address = 2'd3; writedata = 32'h4; chipselect = 1'b1; write_n = 1'b0;
      end else begin
        address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
      end
      @(negedge clk);
      exp_irq = (e == 7) || (e == 27) || (e == 35) || (e == 43) || (e == 51) || (e == 59);
      n_cmp++;
      if (irq !== exp_irq) begin
        n_bad++; $display("FAIL repeat_irq_edge%0d: got %0b expected %0b", e, irq, exp_irq);
      end
      clr_pending = exp_irq;
      if (e >= 62) begin
        exp_state = (e <= 67);
        n_cmp++;
        if (readdata[2] !== exp_state) begin
          n_bad++; $display("FAIL repeat_state_edge%0d: got %0b expected %0b", e, readdata[2], exp_state);
        end
      end
    end
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic test_mask_simul();
    logic [31:0] d;
    bus_write(2'd1, 32'h1);
    bus_write(2'd2, 32'h2);
    btn_n_in = 4'b0110;
    for (int e = 1; e <= 10; e++) begin
      @(negedge clk);
      n_cmp++;
      if (irq !== 1'b0) begin n_bad++; $display("FAIL masked_irq_edge%0d: got %0b expected 0", e, irq); end
    end
    bus_read(2'd3, d);
    n_cmp++;
    if (d !== 32'h9) begin n_bad++; $display("FAIL simul_capture: got %0h expected 9", d); end
    btn_n_in[0] = 1'b1;
    repeat (12) @(negedge clk);
    btn_n_in[0] = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      if (e == 7) begin
        address = 2'd3; writedata = 32'h1; chipselect = 1'b1; write_n = 1'b0;
      end
      @(negedge clk);
    end
    chipselect = 1'b0; write_n = 1'b1;
    bus_read(2'd3, d);
    n_cmp++;
    if (d !== 32'h9) begin n_bad++; $display("FAIL set_beats_clear: got %0h expected 9", d); end
    n_cmp++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL masked_irq_after: got %0b expected 0", irq); end
    bus_write(2'd2, 32'h8);
    n_cmp++;
    if (irq !== 1'b1) begin n_bad++; $display("FAIL unmasked_irq: got %0b expected 1", irq); end
    bus_write(2'd3, 32'hF);
    n_cmp++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL clear_all_irq: got %0b expected 0", irq); end
    btn_n_in = '1;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_enable_abort();
    bus_write(2'd1, 32'h1);
    bus_write(2'd2, 32'hF);
    btn_n_in[0] = 1'b0;
    repeat (4) @(negedge clk);
    bus_write(2'd1, 32'h0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_cmp++;
      if (irq !== 1'b0) begin n_bad++; $display("FAIL abort_irq_c%0d: got %0b expected 0", c, irq); end
    end
    bus_write(2'd1, 32'h1);
    repeat (DEB) @(negedge clk);
    n_cmp++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL reenable_early: got %0b expected 0", irq); end
    @(negedge clk);
    n_cmp++;
    if (irq !== 1'b1) begin n_bad++; $display("FAIL reenable_event: got %0b expected 1", irq); end
    bus_write(2'd3, 32'h1);
    btn_n_in[0] = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_registers();
    logic [31:0] d;
    bus_write(2'd1, 32'hFFFF_FFFF);
    bus_write(2'd2, 32'hFFFF_FFFF);
    address = 2'd2;
    @(negedge clk);
    n_cmp++;
    if (readdata !== 32'hF) begin n_bad++; $display("FAIL mask_readback: got %0h expected f", readdata); end
    address = 2'd1;
    #1;
    n_cmp++;
    if (readdata !== 32'hF) begin n_bad++; $display("FAIL read_not_registered: got %0h expected f", readdata); end
    @(negedge clk);
    n_cmp++;
    if (readdata !== 32'h3) begin n_bad++; $display("FAIL ctrl_readback: got %0h expected 3", readdata); end
    bus_write(2'd1, 32'h1);
    btn_n_in[1] = 1'b0;
    repeat (10) @(negedge clk);
    bus_read(2'd0, d);
    n_cmp++;
    if (d !== 32'h2) begin n_bad++; $display("FAIL state_before_w0: got %0h expected 2", d); end
    bus_write(2'd0, 32'hFFFF_FFFF);
    bus_read(2'd0, d);
    n_cmp++;
    if (d !== 32'h2) begin n_bad++; $display("FAIL state_after_w0: got %0h expected 2", d); end
    bus_read(2'd3, d);
    n_cmp++;
    if (d !== 32'h2) begin n_bad++; $display("FAIL capture_after_w0: got %0h expected 2", d); end
    bus_read(2'd1, d);
    n_cmp++;
    if (d !== 32'h1) begin n_bad++; $display("FAIL ctrl_after_w0: got %0h expected 1", d); end
    bus_write(2'd3, 32'h2);
    btn_n_in[1] = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_random();
    int dur [N_BTN];
    int r;
    for (int i = 0; i < N_BTN; i++) dur[i] = int'($urandom_range(1, 40));
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N_BTN; i++) begin
        if (dur[i] == 0) begin
          btn_n_in[i] = ~btn_n_in[i];
          dur[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(5, 60));
        end else begin
          dur[i]--;
        end
      end
      r = int'($urandom_range(0, 99));
      chipselect = 1'b0; write_n = 1'b1;
      if (r < 3) begin
        address = 2'd1; writedata = $urandom(); chipselect = 1'b1; write_n = 1'b0;
        if ($urandom_range(0, 9) != 0) writedata[0] = 1'b1;
      end else if (r < 5) begin
        address = 2'd2; writedata = $urandom(); chipselect = 1'b1; write_n = 1'b0;
      end else if (r < 15) begin
        address = 2'd3; writedata = $urandom(); chipselect = 1'b1; write_n = 1'b0;
      end else if (r < 16) begin
        address = 2'd0; writedata = $urandom(); chipselect = 1'b1; write_n = 1'b0;
      end else begin
        address = 2'($urandom_range(0, 3)); chipselect = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      n_cmp++;
      if (readdata !== m_rd) begin
        n_bad++; $display("FAIL rand_readdata_c%0d: got %0h expected %0h", c, readdata, m_rd);
      end
      n_cmp++;
      if (irq !== m_irq) begin
        n_bad++; $display("FAIL rand_irq_c%0d: got %0b expected %0b", c, irq, m_irq);
      end
    end
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_mask_simul();
    test_enable_abort();
    test_registers();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
